// File: rtl/mic_level_meter.sv
// Peak-hold volume meter: windowed peak of (mic_in - BASE) mapped to a 0-15 level.
// num/num_valid update on the 2nd posedge after the window-closing sample; no backpressure.
module mic_level_meter #(
  parameter int WINDOW_SAMPLES = 4000,
  parameter int BASE           = 2048,
  parameter int SHIFT          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  input  logic        freeze,
  output logic [3:0]  num,
  output logic        num_valid,
  output logic [11:0] peak_raw
);

  localparam int CW = (WINDOW_SAMPLES > 2) ? $clog2(WINDOW_SAMPLES) : 1;

  typedef enum logic [1:0] {ACCUM, MAP, UPDATE} state_t;

  state_t          state_q;
  logic [CW-1:0]   win_cnt_q;
  logic [11:0]     run_max_q;
  logic [11:0]     peak_raw_q;
  logic [3:0]      pend_level_q;
  logic [3:0]      num_q;
  logic            num_valid_q;

  logic [11:0]     mag;
  logic [11:0]     run_max_d;
  logic [11:0]     peak_shifted;
  logic [3:0]      lvl;
  logic            win_close;

  always_comb begin
    mag          = (mic_in > 12'(BASE)) ? (mic_in - 12'(BASE)) : 12'd0;
    run_max_d    = (mag > run_max_q) ? mag : run_max_q;
    win_close    = sample_valid && (win_cnt_q == CW'(WINDOW_SAMPLES - 1));
    peak_shifted = peak_raw_q >> SHIFT;
    lvl          = (peak_shifted > 12'd15) ? 4'd15 : peak_shifted[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      win_cnt_q    <= '0;
      run_max_q    <= '0;
      peak_raw_q   <= '0;
      pend_level_q <= '0;
      num_q        <= '0;
      num_valid_q  <= 1'b0;
    end else begin
      num_valid_q <= 1'b0;

      // Accumulation runs in every state so samples during MAP/UPDATE are kept.
      if (sample_valid) begin
        if (win_close) begin
          peak_raw_q <= run_max_d;
          run_max_q  <= '0;
          win_cnt_q  <= '0;
        end else begin
          run_max_q  <= run_max_d;
          win_cnt_q  <= win_cnt_q + CW'(1);
        end
      end

      case (state_q)
        ACCUM: begin
          if (win_close) state_q <= MAP;
        end
        MAP: begin
          // Rise instantly, otherwise decay one step (num-1 >= lvl since lvl < num).
          pend_level_q <= (lvl >= num_q) ? lvl : (num_q - 4'd1);
          state_q      <= UPDATE;
        end
        UPDATE: begin
          if (!freeze) begin
            num_q       <= pend_level_q;
            num_valid_q <= 1'b1;
          end
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign peak_raw  = peak_raw_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Directed-vector bench for mic_level_meter with a 4-sample window.
module tb_mic_level_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic        freeze;
  logic [3:0]  num;
  logic        num_valid;
  logic [11:0] peak_raw;

  int n_vec  = 0;
  int n_miss = 0;

  mic_level_meter #(
    .WINDOW_SAMPLES(4),
    .BASE(2048),
    .SHIFT(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .mic_in(mic_in),
    .freeze(freeze),
    .num(num),
    .num_valid(num_valid),
    .peak_raw(peak_raw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives 4 back-to-back samples, then follows the result through MAP and UPDATE.
  task automatic run_window(input string tag, input int s0, input int s1, input int s2,
                            input int s3, input int exp_peak, input int exp_num,
                            input int exp_vld);
    int s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      mic_in       = 12'(s[i]);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk({tag, " peak_raw"}, int'(peak_raw), exp_peak);
    chk({tag, " vld_early0"}, int'(num_valid), 0);
    @(negedge clk);
    chk({tag, " vld_early1"}, int'(num_valid), 0);
    @(negedge clk);
    chk({tag, " num_valid"}, int'(num_valid), exp_vld);
    chk({tag, " num"}, int'(num), exp_num);
    @(negedge clk);
    chk({tag, " vld_after"}, int'(num_valid), 0);
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    mic_in       = 12'd0;
    freeze       = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst num", int'(num), 0);
    chk("rst num_valid", int'(num_valid), 0);
    chk("rst peak_raw", int'(peak_raw), 0);

    run_window("idle", 2048, 2048, 2048, 2048, 0, 0, 1);
    run_window("mixed", 2100, 3000, 2200, 2048, 952, 7, 1);
    run_window("full", 4095, 4095, 4095, 4095, 2047, 15, 1);
    run_window("decay1", 2048, 2048, 2048, 2048, 0, 14, 1);
    run_window("decay2", 2048, 2048, 2048, 2048, 0, 13, 1);
    run_window("decay3", 2048, 2048, 2048, 2048, 0, 12, 1);
    run_window("decay4", 2048, 2048, 2048, 2048, 0, 11, 1);

    // Long quiet stretch: nothing may move.
    repeat (50) @(negedge clk);
    chk("quiet num", int'(num), 11);
    chk("quiet peak_raw", int'(peak_raw), 0);
    chk("quiet num_valid", int'(num_valid), 0);

    do_reset();
    run_window("pre_frz", 2100, 3000, 2200, 2048, 952, 7, 1);
    freeze = 1'b1;
    run_window("frozen", 4095, 4095, 4095, 4095, 2047, 7, 0);
    freeze = 1'b0;
    run_window("release", 2048, 2048, 2048, 2048, 0, 6, 1);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      mic_in       = 12'd4095;
    end
    do_reset();
    chk("midrst num", int'(num), 0);
    chk("midrst num_valid", int'(num_valid), 0);
    chk("midrst peak_raw", int'(peak_raw), 0);
    run_window("postrst", 2300, 2300, 2300, 2300, 252, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
